// File: rtl/search_pkg.sv
// Shared definitions for the successive-approximation search controller and its bench.
package search_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIAL = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A sane comparator raises exactly one of its three relation flags.
    function automatic logic flags_onehot(input logic b_gt, input logic b_a_eq, input logic a_gt);
        return (b_gt ^ b_a_eq ^ a_gt) & ~(b_gt & b_a_eq & a_gt);
    endfunction

endpackage

// File: rtl/binary_search_if.sv
// Controller-side bundle: start/status handshake plus the comparator operand and flags.
interface binary_search_if #(
    parameter int N = 4
);
    logic         start;
    logic         b_gt;
    logic         b_a_eq;
    logic         a_gt;
    logic [N-1:0] cand;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         err;

    modport master (
        output start, b_gt, b_a_eq, a_gt,
        input  cand, busy, done, result, err
    );

    modport slave (
        input  start, b_gt, b_a_eq, a_gt,
        output cand, busy, done, result, err
    );
endinterface

// File: rtl/comparator.sv
// Combinational magnitude comparator reporting b > a, b == a and a > b.
module comparator #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         b_gt,
    output logic         b_a_eq,
    output logic         a_gt
);
    assign b_gt   = (b > a);
    assign b_a_eq = (b == a);
    assign a_gt   = (a > b);
endmodule

// File: rtl/binary_search.sv
// Resolves an unknown N-bit value MSB-first by driving trial candidates into an
// external comparator and reacting to its relation flags, one trial per cycle.
module binary_search
    import search_pkg::*;
#(
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    binary_search_if.slave  bus
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    state_t        state_q, state_nx;
    logic [N-1:0]  cand_q, cand_nx;
    logic [KW-1:0] k_q, k_nx;
    logic [N-1:0]  result_q, result_nx;
    logic          err_q, err_nx;
    logic [N-1:0]  bit_k;

    assign bit_k = N'(1) << k_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            k_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_nx;
            cand_q   <= cand_nx;
            k_q      <= k_nx;
            result_q <= result_nx;
            err_q    <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state_q;
        cand_nx   = cand_q;
        k_nx      = k_q;
        result_nx = result_q;
        err_nx    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_nx  = TRIAL;
                    cand_nx   = N'(1) << (N - 1);
                    k_nx      = KW'(N - 1);
                    result_nx = '0;
                    err_nx    = 1'b0;
                end
            end
            TRIAL: begin
                // Flags are combinational off cand_q, so they judge this cycle's candidate.
                if (!flags_onehot(bus.b_gt, bus.b_a_eq, bus.a_gt)) begin
                    err_nx    = 1'b1;
                    result_nx = cand_q;
                    state_nx  = DONE;
                end else if (bus.b_a_eq) begin
                    result_nx = cand_q;
                    state_nx  = DONE;
                end else if (k_q == '0) begin
                    // At the last bit b_gt would mean b exceeds an all-resolved value.
                    if (bus.a_gt) begin
                        result_nx = cand_q & ~N'(1);
                    end else begin
                        err_nx    = 1'b1;
                        result_nx = cand_q;
                    end
                    state_nx = DONE;
                end else if (bus.b_gt) begin
                    cand_nx = cand_q | (bit_k >> 1);
                    k_nx    = k_q - KW'(1);
                end else begin
                    cand_nx = (cand_q & ~bit_k) | (bit_k >> 1);
                    k_nx    = k_q - KW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.cand   = cand_q;
    assign bus.busy   = (state_q == TRIAL);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_binary_search.sv
// Directed bench: binary_search closed around the comparator with a secret b value.
module tb_binary_search;
    import search_pkg::*;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] secret;
    logic         cmp_b_gt, cmp_b_a_eq, cmp_a_gt;
    logic         force_en;
    logic [2:0]   force_flags;
    int           n_vec;
    int           n_miscmp;

    binary_search_if #(.N(N)) bus ();

    binary_search #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    comparator #(.N(N)) u_cmp (
        .a      (bus.cand),
        .b      (secret),
        .b_gt   (cmp_b_gt),
        .b_a_eq (cmp_b_a_eq),
        .a_gt   (cmp_a_gt)
    );

    // Flag override lets us present inconsistent comparator answers.
    assign bus.b_gt   = force_en ? force_flags[2] : cmp_b_gt;
    assign bus.b_a_eq = force_en ? force_flags[1] : cmp_b_a_eq;
    assign bus.a_gt   = force_en ? force_flags[0] : cmp_a_gt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // cseq holds the expected candidates as nibbles, first trial in the top nibble;
    // cseq == 0 skips candidate checks. fcyc selects the cycle whose flags are forced.
    task automatic run(input string tag, input logic [N-1:0] bv, input logic [15:0] cseq,
                       input int exp_done, input logic [N-1:0] exp_res, input logic exp_err,
                       input logic poke, input int fcyc, input logic [2:0] fval);
        int c;
        logic seen;
        logic [N-1:0] exp_c;
        secret    = bv;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        c    = 1;
        seen = 1'b0;
        while (c <= 8 && !seen) begin
            force_en    = (c == fcyc);
            force_flags = fval;
            bus.start   = poke && (c == 2);
            if (bus.done) begin
                seen = 1'b1;
                check({tag, "_done_cycle"}, c, exp_done);
                check({tag, "_result"}, bus.result, exp_res);
                check({tag, "_err"}, bus.err, exp_err);
                check({tag, "_busy_at_done"}, bus.busy, 0);
            end else begin
                if (cseq != 16'h0 && c < exp_done) begin
                    exp_c = N'(cseq >> (4 * (4 - c)));
                    check({tag, "_cand"}, bus.cand, exp_c);
                end
                step();
                c++;
            end
        end
        force_en  = 1'b0;
        bus.start = 1'b0;
        if (!seen) check({tag, "_done_timeout"}, 0, 1);
        step();
        check({tag, "_done_pulse_width"}, bus.done, 0);
        check({tag, "_idle_not_busy"}, bus.busy, 0);
        check({tag, "_result_held"}, bus.result, exp_res);
        if (cseq != 16'h0) begin
            exp_c = N'(cseq >> (4 * (4 - (exp_done - 1))));
            check({tag, "_cand_held"}, bus.cand, exp_c);
        end
    endtask

    int dtab [16] = '{5, 5, 4, 5, 3, 5, 4, 5, 2, 5, 4, 5, 3, 5, 4, 5};

    initial begin
        n_vec       = 0;
        n_miscmp    = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        secret      = '0;
        force_en    = 1'b0;
        force_flags = 3'b000;
        repeat (3) step();
        check("rst_cand", bus.cand, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_err", bus.err, 0);
        check("cmp_onehot", flags_onehot(bus.b_gt, bus.b_a_eq, bus.a_gt), 1);
        rst_n = 1'b1;
        step();

        run("b11", 4'd11, 16'h8CAB, 5, 4'd11, 1'b0, 1'b0, 0, 3'b000);
        run("b8",  4'd8,  16'h8000, 2, 4'd8,  1'b0, 1'b0, 0, 3'b000);
        run("b0",  4'd0,  16'h8421, 5, 4'd0,  1'b0, 1'b0, 0, 3'b000);
        run("b15", 4'd15, 16'h8CEF, 5, 4'd15, 1'b0, 1'b0, 0, 3'b000);

        for (int b = 0; b < 16; b++) begin
            run($sformatf("sweep%0d", b), N'(b), 16'h0, dtab[b], N'(b), 1'b0, 1'b1, 0, 3'b000);
        end

        run("force000", 4'd11, 16'h8C00, 3, 4'd12, 1'b1, 1'b0, 2, 3'b000);
        run("force110", 4'd11, 16'h8CA0, 4, 4'd10, 1'b1, 1'b0, 3, 3'b110);
        run("force_k0_bgt", 4'd0, 16'h8421, 5, 4'd1, 1'b1, 1'b0, 4, 3'b100);
        run("after_err", 4'd5, 16'h8465, 5, 4'd5, 1'b0, 1'b0, 0, 3'b000);

        secret    = 4'd11;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check("abort_cand_before", bus.cand, 12);
        rst_n = 1'b0;
        step();
        check("abort_cand", bus.cand, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_result", bus.result, 0);
        check("abort_err", bus.err, 0);
        rst_n = 1'b1;
        step();
        check("abort_no_done", bus.done, 0);
        run("post_abort", 4'd11, 16'h8CAB, 5, 4'd11, 1'b0, 1'b0, 0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/binary_search.md
# binary_search

Sequential successive-approximation controller that finds an unknown N-bit value `b` using only an external magnitude comparator. The controller drives the comparator's `a` operand with a trial candidate and reads back its three relation flags (`b_gt`, `b_a_eq`, `a_gt`). It resolves `b` MSB-first in at most N trial cycles. It sits on the comparator's input side, driving `a` and consuming the flags, and works with the existing combinational `comparator` block.

## Interface
- `N`, default 4: operand width in bits; N ≥ 1.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: begin a search; sampled only in IDLE.
- `b_gt`, input, 1: comparator flag, b > cand.
- `b_a_eq`, input, 1: comparator flag, b == cand.
- `a_gt`, input, 1: comparator flag, cand > b.
- `cand`, output, N: candidate driven to the comparator `a` input; registered.
- `busy`, output, 1: high in TRIAL.
- `done`, output, 1: one-cycle pulse when the search ends.
- `result`, output, N: resolved value; valid while `done` is high; held until the next `start` is accepted.
- `err`, output, 1: comparator flags were inconsistent; valid while `done` is high; held with `result`.

## Operation
- States:
  - IDLE: waits for `start`.
  - TRIAL: one candidate per cycle.
  - DONE: one cycle, `done`=1, then returns to IDLE.
- IDLE → TRIAL on `start`=1:
  - `cand` ← 1 << (N-1), bit index k ← N-1.
  - `result` ← 0, `err` ← 0.
- TRIAL, each cycle, flags are evaluated against the current `cand` (the comparator is combinational):
  - Flags not one-hot (zero or several high): `err` ← 1, `result` ← `cand`, go to DONE.
  - `b_a_eq`: `result` ← `cand`, go to DONE (early exit).
  - `b_gt` and k > 0: keep bit k; `cand` ← `cand` | (1 << (k-1)); k ← k-1.
  - `a_gt` and k > 0: clear bit k and set bit k-1 in `cand`; k ← k-1.
  - k = 0 with `a_gt`: `result` ← `cand` with bit 0 cleared, go to DONE.
  - k = 0 with `b_gt`: impossible for a consistent comparator; `err` ← 1, `result` ← `cand`, go to DONE.
- `start` while busy or in DONE: ignored, no queuing.
- Reset values: state IDLE, `cand`=0, `busy`=0, `done`=0, `result`=0, `err`=0.
- Reset asserted mid-search: abort on that edge; all outputs return to reset values, no `done` pulse.
- All candidate arithmetic is N bits wide; no value exceeds 2^N−1, so no wrap-around is possible.

## Timing
- `start` sampled at edge 0 → `cand` = MSB candidate and `busy`=1 from edge 0.
- One trial per cycle; the flags must settle within the same cycle (combinational path from `cand` through the comparator back into this block).
- Latency from the accepting edge to the `done` pulse:
  - Early exit at trial t (1-based): `done` high in cycle t+1.
  - Full search: `done` high in cycle N+1.
- `busy` drops in the same cycle `done` rises.
- The earliest next `start` is accepted in the cycle after `done`.
- `cand` holds its last value through DONE and IDLE until the next search begins.

## Structure
- Shared package `search_pkg`: state enum (IDLE, TRIAL, DONE) and a one-hot flag check function, reused by the bench.
- No sub-module inside this block.
- The bench top instantiates `binary_search` plus the existing `comparator`, with `comparator.b` driven by the secret value.

## Test plan
- N=4, b=11, pulse `start` → `cand` sequence 8, 12, 10, 11; `done` in cycle 5; `result`=11; `err`=0.
- N=4, b=8 → first trial equal; `done` in cycle 2; `result`=8.
- N=4, b=0 → `cand` 8, 4, 2, 1, all `a_gt`; `done` in cycle 5; `result`=0. Likewise b=15 → `cand` 8, 12, 14, 15; `result`=15.
- Sweep b = 0..15 with back-to-back `start` pulses; `start` also pulsed while `busy` → every `result` equals b; `err`=0; extra starts ignored.
- Flags forced to 000 or 110 during TRIAL → `err`=1, `done` pulse, `result`=current `cand`.
- `rst_n`=0 at the second TRIAL cycle of b=11 → next cycle IDLE with all outputs 0; a fresh `start` completes normally.
